// File: rtl/id_stage.sv
// Instruction decode stage: register file with writeback bypass, immediate
// generation, load-use hazard detection and a registered decode bundle.
//
// Handshake: a stage-to-stage transfer happens on a rising edge where the
// producer's valid and the consumer's ready are both 1. Fetch -> decode uses
// if_valid/id_ready; decode -> execute uses id_valid/ex_ready. A producer
// holds its payload stable while valid=1 and ready=0.
module id_stage #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_inst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_wr,
    input  logic [XLEN-1:0]   wb_wd,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_rD1,
    output logic [XLEN-1:0]   id_rD2,
    output logic [XLEN-1:0]   id_imm,
    output logic [REG_AW-1:0] id_rs1,
    output logic [REG_AW-1:0] id_rs2,
    output logic [REG_AW-1:0] id_rd,
    output logic              id_rf_we,
    output logic              id_load
);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [XLEN-1:0]   regs [REG_NUM];

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   rd1_val, rd2_val;
    logic              is_s, is_b, is_u, is_j, is_r;
    logic              use_rs1, use_rs2, rf_we_dec;
    logic              hazard, advance, transfer;

    // Field extraction, immediate generation and source-use classification.
    always_comb begin
        opcode  = if_inst[6:0];
        rs1_idx = if_inst[15 +: REG_AW];
        rs2_idx = if_inst[20 +: REG_AW];
        rd_idx  = if_inst[7 +: REG_AW];
        is_s    = (opcode == OP_STORE);
        is_b    = (opcode == OP_BR);
        is_u    = (opcode == OP_LUI) || (opcode == OP_AUIPC);
        is_j    = (opcode == OP_JAL);
        is_r    = (opcode == OP_REG);
        imm32   = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
            OP_STORE:
                imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            OP_BR:
                imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                         if_inst[30:25], if_inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {if_inst[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                         if_inst[20], if_inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm_ext   = XLEN'($signed(imm32));
        rf_we_dec = !(is_s || is_b) && (rd_idx != '0);
        use_rs1   = !(is_u || is_j);
        use_rs2   = is_r || is_s || is_b;
    end

    // Operand read: x0 is hardwired to zero, a same-cycle writeback wins.
    always_comb begin
        rd1_val = regs[rs1_idx];
        rd2_val = regs[rs2_idx];
        if (wb_we && (wb_wr == rs1_idx)) rd1_val = wb_wd;
        if (wb_we && (wb_wr == rs2_idx)) rd2_val = wb_wd;
        if (rs1_idx == '0) rd1_val = '0;
        if (rs2_idx == '0) rd2_val = '0;
    end

    // Load-use hazard and handshake; reset forces ready so fetch never blocks on it.
    always_comb begin
        hazard = id_valid && id_load && (id_rd != '0) &&
                 ((use_rs1 && (rs1_idx == id_rd)) ||
                  (use_rs2 && (rs2_idx == id_rd)));
        advance  = !id_valid || ex_ready;
        id_ready = !rst_n || (!flush && !hazard && advance);
        transfer = if_valid && id_ready;
    end

    // Register file: writes ignore stall, hold and flush; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wb_we && (wb_wr != '0)) begin
            regs[wb_wr] <= wb_wd;
        end
    end

    // Decode bundle register: flush clears valid, otherwise advance when free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_rD1   <= '0;
            id_rD2   <= '0;
            id_imm   <= '0;
            id_rs1   <= '0;
            id_rs2   <= '0;
            id_rd    <= '0;
            id_rf_we <= 1'b0;
            id_load  <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (advance) begin
            id_valid <= transfer;
            if (transfer) begin
                id_pc    <= if_pc;
                id_rD1   <= rd1_val;
                id_rD2   <= rd2_val;
                id_imm   <= imm_ext;
                id_rs1   <= rs1_idx;
                id_rs2   <= rs2_idx;
                id_rd    <= rd_idx;
                id_rf_we <= rf_we_dec;
                id_load  <= (opcode == OP_LOAD);
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: register file, bypass, immediates, load-use
// stall, backpressure, flush and asynchronous reset.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        ex_ready;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_wd;
    logic        id_valid;
    logic [31:0] id_pc, id_rD1, id_rD2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rf_we, id_load;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] ADDI_X6_X5_M1 = 32'hFFF28313;
    localparam logic [31:0] ADD_X7_X5_X5  = 32'h005283B3;
    localparam logic [31:0] LW_X8_0_X1    = 32'h0000A403;
    localparam logic [31:0] ADD_X9_X8_X2  = 32'h002404B3;
    localparam logic [31:0] SW_X1_4_X2    = 32'h00112223;
    localparam logic [31:0] ADDI_X10_X0_5 = 32'h00500513;
    localparam logic [31:0] LUI_X8_RS1F8  = 32'h00040437;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst),
        .if_pc(if_pc), .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd), .id_valid(id_valid),
        .id_pc(id_pc), .id_rD1(id_rD1), .id_rD2(id_rD2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rf_we(id_rf_we), .id_load(id_load)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Driver: advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        wb_we    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); if_inst = '0; if_pc = '0; wb_wr = '0; wb_wd = '0;
        #3;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", id_valid); end
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", id_ready); end
        checks++; if (id_imm !== 32'h0 || id_pc !== 32'h0) begin failures++; $display("FAIL reset_payload imm=%h pc=%h exp=0", id_imm, id_pc); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        wb_we = 1'b1; wb_wr = 5'd5; wb_wd = 32'hDEADBEEF;
        tick();
        wb_we = 1'b0;
        offer(ADDI_X6_X5_M1, 32'h100);
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%0b exp=1", id_ready); end
        tick();
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL wr_valid got=%0b exp=1", id_valid); end
        checks++; if (id_rD1 !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rD1 got=%h exp=deadbeef", id_rD1); end
        checks++; if (id_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL wr_imm got=%h exp=ffffffff", id_imm); end
        checks++; if (id_rd !== 5'd6 || id_rf_we !== 1'b1 || id_load !== 1'b0) begin failures++; $display("FAIL wr_rd rd=%0d we=%0b ld=%0b exp=6/1/0", id_rd, id_rf_we, id_load); end
        checks++; if (id_pc !== 32'h100 || id_rs1 !== 5'd5) begin failures++; $display("FAIL wr_pc pc=%h rs1=%0d exp=100/5", id_pc, id_rs1); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL wr_drain got=%0b exp=0", id_valid); end
    endtask

    task automatic test_bypass();
        wb_we = 1'b1; wb_wr = 5'd5; wb_wd = 32'h12345678;
        offer(ADD_X7_X5_X5, 32'h104);
        tick();
        idle();
        checks++; if (id_rD1 !== 32'h12345678 || id_rD2 !== 32'h12345678) begin failures++; $display("FAIL bypass_rd got=%h/%h exp=12345678", id_rD1, id_rD2); end
        checks++; if (id_rs2 !== 5'd5 || id_rd !== 5'd7 || id_imm !== 32'h0) begin failures++; $display("FAIL bypass_fields rs2=%0d rd=%0d imm=%h exp=5/7/0", id_rs2, id_rd, id_imm); end
        tick();
    endtask

    task automatic test_imm();
        logic [31:0] insts [4];
        logic [31:0] imms  [4];
        logic        wes   [4];
        insts[0] = 32'h123451B7; imms[0] = 32'h12345000; wes[0] = 1'b1;  // lui x3
        insts[1] = 32'hFE208CE3; imms[1] = 32'hFFFFFFF8; wes[1] = 1'b0;  // beq -8
        insts[2] = 32'hFFDFF0EF; imms[2] = 32'hFFFFFFFC; wes[2] = 1'b1;  // jal -4
        insts[3] = SW_X1_4_X2;   imms[3] = 32'h00000004; wes[3] = 1'b0;  // sw
        for (int i = 0; i < 4; i++) begin
            offer(insts[i], 32'h200 + 32'(i * 4));
            tick();
            checks++; if (id_valid !== 1'b1 || id_imm !== imms[i] || id_rf_we !== wes[i]) begin
                failures++;
                $display("FAIL imm_%0d valid=%0b imm=%h we=%0b exp=1/%h/%0b", i, id_valid, id_imm, id_rf_we, imms[i], wes[i]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_x0();
        wb_we = 1'b1; wb_wr = 5'd0; wb_wd = 32'hFFFFFFFF;
        offer(ADDI_X10_X0_5, 32'h300);
        tick();
        wb_we = 1'b0;
        checks++; if (id_rD1 !== 32'h0 || id_imm !== 32'h5) begin failures++; $display("FAIL x0_bypass rD1=%h imm=%h exp=0/5", id_rD1, id_imm); end
        tick();
        if_valid = 1'b0;
        checks++; if (id_rD1 !== 32'h0 || id_rd !== 5'd10) begin failures++; $display("FAIL x0_read rD1=%h rd=%0d exp=0/10", id_rD1, id_rd); end
        tick();
    endtask

    task automatic test_load_use();
        offer(LW_X8_0_X1, 32'h400);
        tick();
        checks++; if (id_valid !== 1'b1 || id_load !== 1'b1 || id_rd !== 5'd8) begin failures++; $display("FAIL lu_load valid=%0b load=%0b rd=%0d exp=1/1/8", id_valid, id_load, id_rd); end
        offer(ADD_X9_X8_X2, 32'h404);
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_stall_ready got=%0b exp=0", id_ready); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0b exp=0", id_valid); end
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_resume_ready got=%0b exp=1", id_ready); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_rd !== 5'd9 || id_rs1 !== 5'd8 || id_pc !== 32'h404) begin failures++; $display("FAIL lu_accept valid=%0b rd=%0d rs1=%0d pc=%h exp=1/9/8/404", id_valid, id_rd, id_rs1, id_pc); end
        // A U-type whose rs1 field matches the load's rd is not a consumer.
        offer(LW_X8_0_X1, 32'h408);
        tick();
        offer(LUI_X8_RS1F8, 32'h40C);
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_unused_rs got=%0b exp=1", id_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        offer(ADDI_X6_X5_M1, 32'h500);
        tick();
        ex_ready = 1'b0;
        offer(ADD_X7_X5_X5, 32'h504);
        wb_we = 1'b1; wb_wr = 5'd5; wb_wd = 32'hAAAA5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_%0d got=%0b exp=0", i, id_ready); end
            tick();
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h500 || id_rD1 !== 32'h12345678 || id_rd !== 5'd6) begin
                failures++;
                $display("FAIL bp_hold_%0d valid=%0b pc=%h rD1=%h rd=%0d exp=1/500/12345678/6", i, id_valid, id_pc, id_rD1, id_rd);
            end
        end
        wb_we = 1'b0;
        ex_ready = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", id_ready); end
        tick();
        idle();
        checks++; if (id_pc !== 32'h504 || id_rd !== 5'd7 || id_rD1 !== 32'hAAAA5555) begin failures++; $display("FAIL bp_next pc=%h rd=%0d rD1=%h exp=504/7/aaaa5555", id_pc, id_rd, id_rD1); end
        tick();
    endtask

    task automatic test_flush();
        offer(ADDI_X6_X5_M1, 32'h600);
        tick();
        flush = 1'b1;
        offer(ADD_X7_X5_X5, 32'h604);
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", id_ready); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", id_valid); end
        idle();
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%0b exp=0", id_valid); end
    endtask

    task automatic test_reset_mid_stall();
        offer(LW_X8_0_X1, 32'h700);
        tick();
        ex_ready = 1'b0;
        offer(ADD_X9_X8_X2, 32'h704);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_load !== 1'b0 || id_pc !== 32'h0 || id_rd !== 5'd0) begin failures++; $display("FAIL arst_outputs valid=%0b load=%0b pc=%h rd=%0d exp=0", id_valid, id_load, id_pc, id_rd); end
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%0b exp=1", id_ready); end
        #1;
        rst_n = 1'b1;
        ex_ready = 1'b1;
        offer(ADDI_X6_X5_M1, 32'h800);
        tick();
        idle();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h800 || id_rD1 !== 32'h0) begin failures++; $display("FAIL arst_first_edge valid=%0b pc=%h rD1=%h exp=1/800/0", id_valid, id_pc, id_rD1); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_imm();
        test_x0();
        test_load_use();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
